// File: rtl/seg7_pkg.sv
// Shared types, segment patterns and FSM states for the seven-segment readback path.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nib_t;

    // Active-low {g..a} patterns, identical to the HEX display drivers.
    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_A     = 7'h08;
    localparam seg_t SEG_B     = 7'h03;
    localparam seg_t SEG_C     = 7'h46;
    localparam seg_t SEG_D     = 7'h21;
    localparam seg_t SEG_E     = 7'h06;
    localparam seg_t SEG_F     = 7'h0E;
    localparam seg_t SEG_BLANK = 7'h7F;

    typedef enum logic {
        COLLECT,
        PRESENT
    } state_t;

    // Shift-add form of 10*t+u; callers gate out digits above 9.
    function automatic logic [6:0] bin_of(nib_t t, nib_t u);
        logic [6:0] tt;
        tt = {3'b000, t};
        return (tt << 3) + (tt << 1) + {3'b000, u};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low segment pattern decoder: value, blank and illegal flags.
// Define SEG7_READBACK_HEX_AF_EN to accept the A..F glyphs as legal digits 10..15.
module seg7_decode
    import seg7_pkg::*;
(
    input  seg_t        seg,
    output nib_t        value,
    output logic        blank,
    output logic        err
);

    always_comb begin
        value = 4'd0;
        blank = 1'b0;
        err   = 1'b0;
        case (seg)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
`ifdef SEG7_READBACK_HEX_AF_EN
            SEG_A:     value = 4'hA;
            SEG_B:     value = 4'hB;
            SEG_C:     value = 4'hC;
            SEG_D:     value = 4'hD;
            SEG_E:     value = 4'hE;
            SEG_F:     value = 4'hF;
`endif
            SEG_BLANK: blank = 1'b1;
            default:   err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_readback.sv
// Debounced readback of a scanned active-low 4-digit seven-segment bus into frames.
// SEG7_READBACK_HEX_AF_EN (see seg7_decode) makes the A..F glyphs legal.
module seg7_readback
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 3,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [6:0]  SEG_IN,
    input  logic [1:0]  DIG_SEL,
    input  logic        SEG_STROBE,
    input  logic        FRAME_READY,
    output logic        FRAME_VALID,
    output logic [15:0] DIGITS,
    output logic [3:0]  BLANK,
    output logic [3:0]  ERR,
    output logic [6:0]  BIN_VAL,
    output logic        BIN_ERR
);

    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CNT);

    seg_t             last_q [4];
    logic [CNT_W-1:0] cnt_q  [4];
    nib_t             dig_q  [4];
    logic [3:0]       blank_q, err_q, seen_q, seen_d;
    state_t           state_q, state_d;

    nib_t             dec_value;
    logic             dec_blank, dec_err;
    logic [CNT_W-1:0] cur_cnt, new_cnt;
    logic             commit, snapshot;
    logic             bin_bad;
    logic [6:0]       bin_val;

    seg7_decode u_decode (
        .seg   (SEG_IN),
        .value (dec_value),
        .blank (dec_blank),
        .err   (dec_err)
    );

    always_comb begin
        cur_cnt = cnt_q[DIG_SEL];
        new_cnt = CNT_W'(1);
        if (SEG_IN == last_q[DIG_SEL]) begin
            new_cnt = (cur_cnt >= STABLE) ? STABLE : cur_cnt + 1'b1;
        end
        commit   = SEG_STROBE && (new_cnt >= STABLE);
        snapshot = (state_q == COLLECT) && (seen_q == 4'hF);

        // A commit on the snapshot edge belongs to the following frame.
        seen_d = snapshot ? 4'h0 : seen_q;
        if (commit) begin
            seen_d = seen_d | (4'b0001 << DIG_SEL);
        end

        bin_bad = blank_q[1] | blank_q[0] | err_q[1] | err_q[0] |
                  (dig_q[1] > 4'd9) | (dig_q[0] > 4'd9);
        bin_val = bin_bad ? 7'd0 : bin_of(dig_q[1], dig_q[0]);

        state_d = state_q;
        case (state_q)
            COLLECT: if (snapshot)    state_d = PRESENT;
            PRESENT: if (FRAME_READY) state_d = COLLECT;
            default:                  state_d = COLLECT;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                last_q[i] <= SEG_BLANK;
                cnt_q[i]  <= '0;
                dig_q[i]  <= 4'd0;
            end
            blank_q <= 4'h0;
            err_q   <= 4'h0;
            seen_q  <= 4'h0;
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
            if (SEG_STROBE) begin
                last_q[DIG_SEL] <= SEG_IN;
                cnt_q[DIG_SEL]  <= new_cnt;
            end
            if (commit) begin
                dig_q[DIG_SEL]   <= dec_value;
                blank_q[DIG_SEL] <= dec_blank;
                err_q[DIG_SEL]   <= dec_err;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            FRAME_VALID <= 1'b0;
            DIGITS      <= 16'h0000;
            BLANK       <= 4'h0;
            ERR         <= 4'h0;
            BIN_VAL     <= 7'd0;
            BIN_ERR     <= 1'b0;
        end else if (snapshot) begin
            FRAME_VALID <= 1'b1;
            DIGITS      <= {dig_q[3], dig_q[2], dig_q[1], dig_q[0]};
            BLANK       <= blank_q;
            ERR         <= err_q;
            BIN_VAL     <= bin_val;
            BIN_ERR     <= bin_bad;
        end else if ((state_q == PRESENT) && FRAME_READY) begin
            FRAME_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_readback.sv
// Directed bench for seg7_readback with a frame-level reference model checked every cycle.
module tb_seg7_readback;

    localparam int STABLE = 3;

    logic        CLOCK_50 = 1'b0;
    logic        RESET;
    logic [6:0]  SEG_IN;
    logic [1:0]  DIG_SEL;
    logic        SEG_STROBE;
    logic        FRAME_READY;
    logic        FRAME_VALID;
    logic [15:0] DIGITS;
    logic [3:0]  BLANK;
    logic [3:0]  ERR;
    logic [6:0]  BIN_VAL;
    logic        BIN_ERR;

    int tests = 0;
    int fails = 0;

    seg7_readback #(.STABLE_CNT(3), .CNT_W(4)) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .SEG_IN      (SEG_IN),
        .DIG_SEL     (DIG_SEL),
        .SEG_STROBE  (SEG_STROBE),
        .FRAME_READY (FRAME_READY),
        .FRAME_VALID (FRAME_VALID),
        .DIGITS      (DIGITS),
        .BLANK       (BLANK),
        .ERR         (ERR),
        .BIN_VAL     (BIN_VAL),
        .BIN_ERR     (BIN_ERR)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

`ifdef SEG7_READBACK_HEX_AF_EN
    localparam int NLEGAL = 16;
`else
    localparam int NLEGAL = 10;
`endif

    // Reference model state: what each digit position shows and what the consumer sees.
    logic [6:0] m_last [4];
    int         m_cnt  [4];
    int         m_val  [4];
    bit         m_blank[4];
    bit         m_err  [4];
    bit [3:0]   m_seen;
    bit         m_present;
    bit         e_fv;
    logic [15:0] e_dig;
    logic [3:0] e_blank, e_err;
    int         e_bin;
    bit         e_binerr;

    function automatic void decode(input logic [6:0] p, output int v, output bit bl, output bit er);
        logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        v = 0; bl = (p == 7'h7F); er = !bl;
        for (int i = 0; i < NLEGAL; i++) begin
            if (p == tbl[i]) begin
                v = i; er = 0;
            end
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_last[i] = 7'h7F; m_cnt[i] = 0; m_val[i] = 0; m_blank[i] = 0; m_err[i] = 0;
        end
        m_seen = 0; m_present = 0;
        e_fv = 0; e_dig = 0; e_blank = 0; e_err = 0; e_bin = 0; e_binerr = 0;
    endtask

    task automatic model_step();
        int d;
        if (RESET) begin
            model_reset();
            return;
        end
        if (!m_present && m_seen == 4'hF) begin
            e_fv = 1;
            for (int i = 0; i < 4; i++) begin
                e_dig[i*4 +: 4] = 4'(m_val[i]);
                e_blank[i] = m_blank[i];
                e_err[i]   = m_err[i];
            end
            e_binerr = m_blank[0] || m_blank[1] || m_err[0] || m_err[1] ||
                       m_val[0] > 9 || m_val[1] > 9;
            e_bin = e_binerr ? 0 : 10 * m_val[1] + m_val[0];
            m_seen = 0;
            m_present = 1;
        end else if (m_present && FRAME_READY) begin
            e_fv = 0;
            m_present = 0;
        end
        if (SEG_STROBE) begin
            d = int'(DIG_SEL);
            if (SEG_IN == m_last[d]) begin
                m_cnt[d] = (m_cnt[d] + 1 > STABLE) ? STABLE : m_cnt[d] + 1;
            end else begin
                m_last[d] = SEG_IN;
                m_cnt[d]  = 1;
            end
            if (m_cnt[d] >= STABLE) begin
                decode(SEG_IN, m_val[d], m_blank[d], m_err[d]);
                m_seen[d] = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLOCK_50 or posedge RESET);
            model_step();
        end
    end

    initial begin
        forever begin
            @(posedge CLOCK_50);
            #1;
            chk("model FRAME_VALID", 32'(FRAME_VALID), 32'(e_fv));
            chk("model DIGITS", 32'(DIGITS), 32'(e_dig));
            chk("model BLANK", 32'(BLANK), 32'(e_blank));
            chk("model ERR", 32'(ERR), 32'(e_err));
            chk("model BIN_VAL", 32'(BIN_VAL), 32'(e_bin));
            chk("model BIN_ERR", 32'(BIN_ERR), 32'(e_binerr));
        end
    end

    task automatic strobes(input int d, input logic [6:0] p, input int n);
        repeat (n) begin
            @(negedge CLOCK_50);
            SEG_STROBE = 1'b1;
            DIG_SEL    = 2'(d);
            SEG_IN     = p;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLOCK_50);
            SEG_STROBE = 1'b0;
        end
    endtask

    initial begin
        RESET = 1'b1; SEG_IN = 7'h7F; DIG_SEL = 2'd0; SEG_STROBE = 1'b0; FRAME_READY = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        RESET = 1'b0;
        chk("reset FRAME_VALID", 32'(FRAME_VALID), 32'd0);
        chk("reset DIGITS", 32'(DIGITS), 32'd0);

        // Frame 1: 3,1,2,0 on HEX0..HEX3.
        strobes(0, 7'h30, 3);
        strobes(1, 7'h79, 3);
        strobes(2, 7'h24, 3);
        strobes(3, 7'h40, 3);
        idle(1);
        chk("f1 not yet valid", 32'(FRAME_VALID), 32'd0);
        @(posedge CLOCK_50); #2;
        chk("f1 FRAME_VALID", 32'(FRAME_VALID), 32'd1);
        chk("f1 DIGITS", 32'(DIGITS), 32'h0213);
        chk("f1 ERR", 32'(ERR), 32'd0);
        chk("f1 BLANK", 32'(BLANK), 32'd0);
        chk("f1 BIN_VAL", 32'(BIN_VAL), 32'd13);
        chk("f1 BIN_ERR", 32'(BIN_ERR), 32'd0);

        // Frame 2 collected while frame 1 is held: illegal, blank, A-glyph, 9.
        strobes(0, 7'h4A, 3);
        strobes(1, 7'h7F, 3);
        strobes(2, 7'h08, 3);
        strobes(3, 7'h10, 3);
        idle(3);
        chk("frozen DIGITS", 32'(DIGITS), 32'h0213);
        chk("frozen FRAME_VALID", 32'(FRAME_VALID), 32'd1);
        @(negedge CLOCK_50); FRAME_READY = 1'b1;
        @(negedge CLOCK_50); FRAME_READY = 1'b0;
        chk("gap FRAME_VALID", 32'(FRAME_VALID), 32'd0);
        @(posedge CLOCK_50); #2;
        chk("f2 FRAME_VALID", 32'(FRAME_VALID), 32'd1);
`ifdef SEG7_READBACK_HEX_AF_EN
        chk("f2 DIGITS", 32'(DIGITS), 32'h9A00);
        chk("f2 ERR", 32'(ERR), 32'h1);
`else
        chk("f2 DIGITS", 32'(DIGITS), 32'h9000);
        chk("f2 ERR", 32'(ERR), 32'h5);
`endif
        chk("f2 BLANK", 32'(BLANK), 32'h2);
        chk("f2 BIN_VAL", 32'(BIN_VAL), 32'd0);
        chk("f2 BIN_ERR", 32'(BIN_ERR), 32'd1);

        // Accept, start a frame, then reset between the 6th and 7th strobe.
        @(negedge CLOCK_50); FRAME_READY = 1'b1;
        @(negedge CLOCK_50); FRAME_READY = 1'b0;
        strobes(0, 7'h30, 3);
        strobes(1, 7'h79, 3);
        @(negedge CLOCK_50); SEG_STROBE = 1'b0; RESET = 1'b1;
        #2;
        chk("midreset FRAME_VALID", 32'(FRAME_VALID), 32'd0);
        chk("midreset DIGITS", 32'(DIGITS), 32'd0);
        chk("midreset BLANK", 32'(BLANK), 32'd0);
        chk("midreset ERR", 32'(ERR), 32'd0);
        @(negedge CLOCK_50); RESET = 1'b0;

        // Fresh frame; digit 0 sees 3,3,5,5 then a final 5.
        strobes(1, 7'h79, 3);
        strobes(2, 7'h24, 3);
        strobes(3, 7'h40, 3);
        strobes(0, 7'h30, 2);
        strobes(0, 7'h12, 2);
        idle(1);
        @(posedge CLOCK_50); #2;
        chk("no early commit", 32'(FRAME_VALID), 32'd0);
        strobes(0, 7'h12, 1);
        idle(1);
        @(posedge CLOCK_50); #2;
        chk("f3 FRAME_VALID", 32'(FRAME_VALID), 32'd1);
        chk("f3 DIGITS", 32'(DIGITS), 32'h0215);
        chk("f3 BIN_VAL", 32'(BIN_VAL), 32'd15);
        chk("f3 BIN_ERR", 32'(BIN_ERR), 32'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
